// File: rtl/button_event_decoder_if.sv
// Handshake bundle between the debounce stage, the press classifier and the
// UI logic: tick enable and button level in, classified event pulses out.
interface button_event_decoder_if;
    logic slow_clk;       // one-cycle tick enable, 5 ms period
    logic btn_level;      // debounced level, 1 = pressed
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    // Stimulus side: drives the tick and the level, observes the events
    modport master (
        output slow_clk,
        output btn_level,
        input  press_pulse,
        input  release_pulse,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held
    );

    // Classifier side: consumes the tick and the level, produces the events
    modport slave (
        input  slow_clk,
        input  btn_level,
        output press_pulse,
        output release_pulse,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies each debounced button press as short, long or auto-repeating and
// emits registered single-cycle event pulses plus a registered 'held' level.
module button_event_decoder #(
    parameter int LONG_TICKS   = 100,  // ticks to reach long press, 1..2^CNT_W-1
    parameter int REPEAT_TICKS = 20,   // ticks between repeats, 0 = no repeat
    parameter int CNT_W        = 8
) (
    input  logic                   regular_clk,
    input  logic                   reset_n,
    button_event_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    // Terminal counts: the counter reaches these on the tick that completes
    // the interval, then clears.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam bit               REPEAT_EN   = (REPEAT_TICKS != 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_short_pulse;
    logic             r_long_pulse;
    logic             r_repeat_pulse;
    logic             r_held;

    // Press classifier: state, tick counter and all registered outputs.
    // A release always takes priority over a coincident tick.
    always_ff @(posedge regular_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_short_pulse   <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_repeat_pulse  <= 1'b0;
            r_held          <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_short_pulse   <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_repeat_pulse  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.btn_level) begin
                        r_state       <= ST_PRESSED;
                        r_cnt         <= '0;
                        r_press_pulse <= 1'b1;
                        r_held        <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!bus.btn_level) begin
                        r_state         <= ST_IDLE;
                        r_cnt           <= '0;
                        r_short_pulse   <= 1'b1;
                        r_release_pulse <= 1'b1;
                        r_held          <= 1'b0;
                    end else if (bus.slow_clk) begin
                        if (r_cnt == LONG_LAST) begin
                            r_state      <= ST_LONG_HELD;
                            r_cnt        <= '0;
                            r_long_pulse <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LONG_HELD: begin
                    if (!bus.btn_level) begin
                        r_state         <= ST_IDLE;
                        r_cnt           <= '0;
                        r_release_pulse <= 1'b1;
                        r_held          <= 1'b0;
                    end else if (bus.slow_clk && REPEAT_EN) begin
                        if (r_cnt == REPEAT_LAST) begin
                            r_cnt          <= '0;
                            r_repeat_pulse <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.short_pulse   = r_short_pulse;
    assign bus.long_pulse    = r_long_pulse;
    assign bus.repeat_pulse  = r_repeat_pulse;
    assign bus.held          = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: two instances (repeat enabled / disabled)
// share clock, reset and stimulus; each is compared every cycle against a
// model that counts total ticks held since press start.
module tb_button_event_decoder;

    localparam int L0 = 4, R0 = 2;   // instance 0: long + repeat
    localparam int L1 = 2, R1 = 0;   // instance 1: repeat disabled

    logic regular_clk = 1'b0;
    logic reset_n     = 1'b0;

    button_event_decoder_if bus0 ();
    button_event_decoder_if bus1 ();

    button_event_decoder #(.LONG_TICKS(L0), .REPEAT_TICKS(R0), .CNT_W(8)) u_dut0 (
        .regular_clk (regular_clk),
        .reset_n     (reset_n),
        .bus         (bus0.slave)
    );

    button_event_decoder #(.LONG_TICKS(L1), .REPEAT_TICKS(R1), .CNT_W(8)) u_dut1 (
        .regular_clk (regular_clk),
        .reset_n     (reset_n),
        .bus         (bus1.slave)
    );

    always #5 regular_clk = ~regular_clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state: whether a press is in progress and how many ticks it
    // has accumulated in total (never cleared by thresholds).
    bit         m_pressed [2];
    int         m_ticks   [2];
    logic [5:0] m_exp     [2];   // {held, repeat, long, short, release, press}

    int long_cnt1, rep_cnt1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int lt(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    function automatic int rt(input int i);
        return (i == 0) ? R0 : R1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pressed[i] = 1'b0;
            m_ticks[i]   = 0;
            m_exp[i]     = '0;
        end
    endtask

    task automatic model_step(input int i, input bit b, input bit s);
        logic [5:0] e;
        e = '0;
        if (!m_pressed[i]) begin
            if (b) begin
                m_pressed[i] = 1'b1;
                m_ticks[i]   = 0;
                e[0]         = 1'b1;
            end
        end else if (!b) begin
            m_pressed[i] = 1'b0;
            e[1]         = 1'b1;
            e[2]         = (m_ticks[i] < lt(i));
        end else if (s) begin
            m_ticks[i]++;
            if (m_ticks[i] == lt(i))
                e[3] = 1'b1;
            else if (m_ticks[i] > lt(i) && rt(i) != 0 && ((m_ticks[i] - lt(i)) % rt(i)) == 0)
                e[4] = 1'b1;
        end
        e[5]     = m_pressed[i];
        m_exp[i] = e;
    endtask

    function automatic logic [5:0] dut_vec0();
        return {bus0.held, bus0.repeat_pulse, bus0.long_pulse,
                bus0.short_pulse, bus0.release_pulse, bus0.press_pulse};
    endfunction

    function automatic logic [5:0] dut_vec1();
        return {bus1.held, bus1.repeat_pulse, bus1.long_pulse,
                bus1.short_pulse, bus1.release_pulse, bus1.press_pulse};
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_u0"}, 32'(dut_vec0()), 32'(m_exp[0]));
        check({tag, "_u1"}, 32'(dut_vec1()), 32'(m_exp[1]));
    endtask

    // One clock cycle: inputs applied at the falling edge, model advanced at
    // the rising edge, DUT outputs compared at the next falling edge.
    task automatic cycle(input string tag, input bit b, input bit s);
        bus0.btn_level = b; bus0.slow_clk = s;
        bus1.btn_level = b; bus1.slow_clk = s;
        @(posedge regular_clk);
        if (reset_n) begin
            model_step(0, b, s);
            model_step(1, b, s);
        end else begin
            model_reset();
        end
        @(negedge regular_clk);
        if (bus1.long_pulse)   long_cnt1++;
        if (bus1.repeat_pulse) rep_cnt1++;
        compare_all(tag);
    endtask

    // Hold the button for n ticks, each tick preceded by one idle cycle
    task automatic hold_ticks(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            cycle(tag, 1'b1, 1'b0);
            cycle(tag, 1'b1, 1'b1);
        end
    endtask

    initial begin
        model_reset();
        bus0.btn_level = 1'b1; bus0.slow_clk = 1'b0;
        bus1.btn_level = 1'b1; bus1.slow_clk = 1'b0;

        // Reset held with the button down: all outputs stay low
        for (int k = 0; k < 3; k++) cycle("reset_hold", 1'b1, 1'b0);
        @(negedge regular_clk);
        reset_n = 1'b1;
        cycle("reset_release_press", 1'b1, 1'b0);
        check("press_after_reset", 32'(bus0.press_pulse), 32'd1);
        cycle("release_a", 1'b0, 1'b0);

        // Short press: 3 ticks then release
        cycle("short_press", 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle("short_tick", 1'b1, 1'b1);
        cycle("short_release", 1'b0, 1'b0);
        check("short_pulse_u0", 32'(bus0.short_pulse), 32'd1);
        cycle("gap", 1'b0, 1'b0);

        // Long + repeat: hold for 10 ticks then release
        cycle("long_press", 1'b1, 1'b0);
        hold_ticks("long_hold", 10);
        cycle("long_release", 1'b0, 1'b0);
        check("long_rel_no_short_u0", 32'(bus0.short_pulse), 32'd0);

        // Back-to-back: new press the cycle after release
        cycle("b2b_press", 1'b1, 1'b0);
        cycle("b2b_release", 1'b0, 1'b0);
        cycle("b2b_press2", 1'b1, 1'b0);
        cycle("b2b_release2", 1'b0, 1'b0);

        // Release coinciding with the tick that would reach the long threshold
        cycle("collide_press", 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle("collide_tick", 1'b1, 1'b1);
        cycle("collide_release", 1'b0, 1'b1);
        check("collide_no_long_u0", 32'(bus0.long_pulse), 32'd0);
        cycle("gap", 1'b0, 1'b0);

        // Repeat disabled on instance 1: 50-tick hold gives one long pulse
        long_cnt1 = 0; rep_cnt1 = 0;
        cycle("norep_press", 1'b1, 1'b0);
        hold_ticks("norep_hold", 50);
        check("norep_long_count_u1", 32'(long_cnt1), 32'd1);
        check("norep_repeat_count_u1", 32'(rep_cnt1), 32'd0);
        cycle("norep_release", 1'b0, 1'b0);

        // Asynchronous reset in LONG_HELD with repeat counter at 1 (instance 0)
        cycle("ar_press", 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle("ar_tick", 1'b1, 1'b1);
        check("ar_held_before_u0", 32'(bus0.held), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_reset_immediate");
        bus0.btn_level = 1'b0; bus1.btn_level = 1'b0;
        @(negedge regular_clk);
        cycle("ar_in_reset", 1'b0, 1'b0);
        @(negedge regular_clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) cycle("ar_after_idle", 1'b0, 1'b1);

        // Randomized presses with random tick placement
        for (int p = 0; p < 60; p++) begin
            int hold_len, gap_len;
            hold_len = $urandom_range(1, 40);
            gap_len  = $urandom_range(1, 4);
            for (int h = 0; h < hold_len; h++)
                cycle("rand_hold", 1'b1, ($urandom_range(0, 2) == 0));
            for (int g = 0; g < gap_len; g++)
                cycle("rand_gap", 1'b0, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the debounced button level and classifies each press as short, long, or auto-repeating, emitting single-cycle event pulses. Sits between the button debounce stage and the UI/control logic, sharing the 31.5 MHz system clock and the slow tick enable (5 ms period) that drives debouncing. Lets downstream logic use long-press and hold-to-repeat gestures without its own timers.

## Interface

- LONG_TICKS, 100: slow ticks a press must last to count as long (100 × 5 ms = 500 ms); legal range 1..2^CNT_W-1
- REPEAT_TICKS, 20: slow ticks between repeat pulses once long (100 ms); 0 disables repeat
- CNT_W, 8: tick counter width

- regular_clk  in  1  system clock, 31.5 MHz; the single clock of the block
- reset_n  in  1  asynchronous, active-low reset
- slow_clk  in  1  tick enable, high for exactly one regular_clk cycle per 5 ms
- btn_level  in  1  debounced button level, 1 = pressed, synchronous to regular_clk
- press_pulse  out  1  one-cycle pulse on press start
- release_pulse  out  1  one-cycle pulse on every release
- short_pulse  out  1  one-cycle pulse on release before the long threshold
- long_pulse  out  1  one-cycle pulse when the long threshold is reached while still held
- repeat_pulse  out  1  one-cycle pulse every REPEAT_TICKS ticks while in long hold
- held  out  1  level, high in PRESSED or LONG_HELD

## Operation

- States: IDLE, PRESSED, LONG_HELD; 2-bit state register; CNT_W-bit tick counter cnt.
- IDLE: btn_level=1 -> PRESSED, cnt=0, press_pulse.
- PRESSED:
  - btn_level=0 -> IDLE, short_pulse + release_pulse.
  - Otherwise, on slow_clk: if cnt==LONG_TICKS-1 -> LONG_HELD, cnt=0, long_pulse; else cnt+1.
- LONG_HELD:
  - btn_level=0 -> IDLE, release_pulse only (no short_pulse).
  - Otherwise, on slow_clk with REPEAT_TICKS≠0: if cnt==REPEAT_TICKS-1 -> cnt=0, repeat_pulse; else cnt+1.
  - REPEAT_TICKS==0: cnt frozen, no repeat pulses.
- Simultaneous release and slow_clk: release wins. No long_pulse or repeat_pulse in that cycle; cnt is not incremented.
- Counter never wraps; it is cleared on every state entry and at each threshold.
- First tick in PRESSED may come anywhere from 0 to 5 ms after press, so long-press duration is LONG_TICKS ticks with a resolution of −1 tick.
- At most one of press/short/long/repeat is high in any cycle. release_pulse coincides only with short_pulse.

## Timing

- All outputs are registered.
- Reset (reset_n low, asynchronous) sets state=IDLE, cnt=0, and all outputs (five pulses and held) to 0. They stay 0 until the first rising regular_clk edge after reset_n deasserts.
- Latency: a condition sampled at edge k drives its output high from edge k to edge k+1, i.e. 1 cycle after btn_level/slow_clk are seen.
- held rises with press_pulse and falls with release_pulse.
- Minimum press: btn_level high for 1 cycle gives press_pulse, then short_pulse + release_pulse in the next cycle.
- Back-to-back: release then btn_level=1 on the very next cycle is accepted as a new press (press_pulse 1 cycle after release_pulse).
- Reset mid-press: no pulses are emitted. After reset, if btn_level is still high, a fresh press_pulse is issued.

## Test plan

- Reset: hold reset_n=0 with btn_level=1 -> all outputs 0. Release reset -> press_pulse exactly 1 cycle later, held=1.
- Short press (LONG_TICKS=4): press, 3 slow_clk ticks, release -> press_pulse, then short_pulse + release_pulse together. long_pulse never asserted.
- Long + repeat (LONG_TICKS=4, REPEAT_TICKS=2): hold for 10 ticks -> long_pulse on tick 4, repeat_pulse on ticks 6, 8, 10. Release -> release_pulse only, no short_pulse.
- Boundary collision (LONG_TICKS=4): drop btn_level in the same cycle as tick 4 -> short_pulse + release_pulse, no long_pulse, state IDLE.
- Repeat disabled (REPEAT_TICKS=0, LONG_TICKS=2): hold for 50 ticks -> exactly one long_pulse, zero repeat_pulse.
- Reset mid-hold: assert reset_n=0 in LONG_HELD at cnt=1 -> outputs 0 immediately, asynchronously. Deassert with btn_level=0 -> stays IDLE, no pulses.
